// File: rtl/alu_resp_pipe.sv
`timescale 1ns/1ps
// alu_resp_pipe
//   Responder end of the ALU request interface. A request (alu_cntr/a/b) is
//   taken under an in_valid/in_ready handshake, registered in stage 1, and
//   evaluated into the stage-2 result/flag register. That register drives the
//   response outputs directly, under an out_valid/out_ready handshake.
//   Throughput is one operation per cycle when the consumer does not stall.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rstn       : asynchronous reset, active low
//   in_valid   : request valid
//   in_ready   : request accepted when in_valid & in_ready
//   alu_cntr   : opcode
//   a, b       : operands; shifts use only the low log2(DATA_W) bits of b
//   out_valid  : response valid
//   out_ready  : response consumed when out_valid & out_ready
//   alu_result : result
//   o_flag     : signed overflow, set for ADD/SUB only
//   z_flag     : alu_result == 0
//   busy       : at least one stage holds an operation
module alu_resp_pipe #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        alu_cntr,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] alu_result,
   output logic              o_flag,
   output logic              z_flag,
   output logic              busy
);

   localparam int unsigned SH_W = $clog2(DATA_W);
   localparam int unsigned MSB  = DATA_W - 1;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_AND  = 4'b0010,
      OP_OR   = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SLL  = 4'b0101,
      OP_SRL  = 4'b0110,
      OP_SRA  = 4'b0111,
      OP_SLT  = 4'b1000,
      OP_SLTU = 4'b1001
   } alu_op_e;

   // stage 1: captured request
   logic              s1_valid;
   alu_op_e           s1_op;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;

   // stage 2: result register, drives the outputs
   logic              s2_valid;

   // in_ready is held low through reset and rises on the first edge after release
   logic              rst_done;

   logic              s2_load;
   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;
   logic [SH_W-1:0]   shamt;
   logic [DATA_W-1:0] res_d;
   logic              ovf_d;

   // stage 2 accepts whenever it is empty or its content leaves this cycle;
   // stage 1 may accept whenever it is empty or moves into stage 2
   assign s2_load   = !s2_valid || out_ready;
   assign in_ready  = rst_done && (!s1_valid || s2_load);
   assign out_valid = s2_valid;
   assign busy      = s1_valid || s2_valid;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rst_done <= 1'b0;
      end else begin
         rst_done <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid <= 1'b0;
         s1_op    <= OP_ADD;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_op <= alu_op_e'(alu_cntr);
            s1_a  <= a;
            s1_b  <= b;
         end
      end
   end

   always_comb begin
      sum   = s1_a + s1_b;
      diff  = s1_a - s1_b;
      shamt = s1_b[SH_W-1:0];
      res_d = '0;
      ovf_d = 1'b0;
      case (s1_op)
         OP_ADD: begin
            res_d = sum;
            ovf_d = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
         end
         OP_SUB: begin
            res_d = diff;
            ovf_d = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
         end
         OP_AND:  res_d = s1_a & s1_b;
         OP_OR:   res_d = s1_a | s1_b;
         OP_XOR:  res_d = s1_a ^ s1_b;
         OP_SLL:  res_d = s1_a << shamt;
         OP_SRL:  res_d = s1_a >> shamt;
         OP_SRA:  res_d = $unsigned($signed(s1_a) >>> shamt);
         OP_SLT:  res_d = {{(DATA_W-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
         OP_SLTU: res_d = {{(DATA_W-1){1'b0}}, (s1_a < s1_b)};
         default: begin
            res_d = '0;
            ovf_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s2_valid   <= 1'b0;
         alu_result <= '0;
         o_flag     <= 1'b0;
         z_flag     <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            alu_result <= res_d;
            o_flag     <= ovf_d;
            z_flag     <= (res_d == '0);
         end
      end
   end

endmodule
